// File: rtl/vertical_projection.sv
// Column projection of binarised ink inside a row window; emits left/right ink bounds per frame.
// Latency: results appear DISPLAY_WIDTH+2 clks after vsync falls (one-clk proj_done pulse).
// Backpressure: none; pixels arriving outside ACCUM are dropped, and SCAN runs without clken.
//
// Ports:
//   clk, reset (async, active-low)
//   vsync       - high during the active frame; its falling edge starts the column scan
//   href        - line reference, not used in any decision
//   clken, bin  - pixel strobe and binarised pixel (1 = ink)
//   line_top, line_bottom - row window; rows strictly inside it are accumulated
//   line_left, line_right - registered column bounds of the ink
//   proj_done   - one-clk pulse when line_left/line_right update
module vertical_projection #(
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 480,
  parameter int COL_THRESH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        href,
  input  logic        clken,
  input  logic        bin,
  input  logic [10:0] line_top,
  input  logic [10:0] line_bottom,
  output logic [10:0] line_left,
  output logic [10:0] line_right,
  output logic        proj_done
);

  localparam int AW = (DISPLAY_WIDTH > 1) ? $clog2(DISPLAY_WIDTH) : 1;
  localparam int CW = $clog2(DISPLAY_WIDTH + 2);
  localparam logic [AW-1:0] X_LAST        = AW'(DISPLAY_WIDTH - 1);
  localparam logic [10:0]   RIGHT_DEFAULT = 11'(DISPLAY_WIDTH - 1);
  localparam logic [9:0]    THRESH        = 10'(COL_THRESH);
  localparam logic [9:0]    CNT_MAX       = 10'h3FF;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Shared sequencer: CLEAR write address, or SCAN cycle index (0..DISPLAY_WIDTH+1).
  logic [CW-1:0] cnt;
  logic [AW-1:0] x_cnt;
  logic [10:0]   y_cnt;
  logic          vsync_d;

  // Inputs with no effect on the datapath.
  logic unused_inputs;
  assign unused_inputs = href ^ (DISPLAY_HEIGHT == 0);

  // Column histogram, no reset: CLEAR initialises it.
  logic [9:0] col_mem [DISPLAY_WIDTH];
  logic [9:0] rd_data;

  // Read stage (pixel accumulate or scan read) and its one-cycle-later write-back.
  logic          acc_hit, scan_rd, rd_en;
  logic [AW-1:0] rd_addr;
  logic          we;
  logic [AW-1:0] wa;
  logic [9:0]    wd;

  logic          s1_vld, s1_scan, s1_inc, s1_byp;
  logic [AW-1:0] s1_addr;
  logic [9:0]    s1_byp_dat;
  logic [9:0]    old_val, sum;

  logic          found, hit, nxt_found;
  logic [AW-1:0] run_left, run_right, nxt_left, nxt_right;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == CW'(DISPLAY_WIDTH - 1)) state_nxt = ACCUM;
      ACCUM:   if (vsync_d && !vsync)             state_nxt = SCAN;
      SCAN:    if (cnt == CW'(DISPLAY_WIDTH + 1)) state_nxt = ACCUM;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (state != ACCUM)     cnt <= cnt + 1'b1;
  end

  // ---------------- pixel counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (!vsync) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (clken) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 11'd1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- histogram access ----------------
  assign acc_hit = (state == ACCUM) && clken && vsync &&
                   (y_cnt > line_top) && (y_cnt < line_bottom);
  assign scan_rd = (state == SCAN) && (cnt < CW'(DISPLAY_WIDTH));
  assign rd_en   = acc_hit || scan_rd;
  assign rd_addr = scan_rd ? cnt[AW-1:0] : x_cnt;

  // A write landing on the same edge as a read of the same address would be
  // missed by the memory read, so the pending data is forwarded instead.
  assign old_val = s1_byp ? s1_byp_dat : rd_data;
  assign sum     = (old_val == CNT_MAX) ? old_val : old_val + {9'd0, s1_inc};

  always_comb begin
    we = 1'b0;
    wa = s1_addr;
    wd = sum;
    if (state == CLEAR) begin
      we = 1'b1;
      wa = cnt[AW-1:0];
      wd = '0;
    end else if (s1_vld) begin
      we = 1'b1;
      wa = s1_addr;
      wd = s1_scan ? 10'd0 : sum;   // scan reads clear the column behind them
    end
  end

  always_ff @(posedge clk) begin
    if (we)    col_mem[wa] <= wd;
    if (rd_en) rd_data     <= col_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld     <= 1'b0;
      s1_scan    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_addr    <= '0;
      s1_byp     <= 1'b0;
      s1_byp_dat <= '0;
    end else begin
      s1_vld     <= rd_en;
      s1_scan    <= scan_rd;
      s1_inc     <= bin;
      s1_addr    <= rd_addr;
      s1_byp     <= rd_en && we && (wa == rd_addr);
      s1_byp_dat <= wd;
    end
  end

  // ---------------- scan evaluation ----------------
  assign hit       = s1_vld && s1_scan && (old_val > THRESH);
  assign nxt_found = found || hit;
  assign nxt_left  = (hit && !found) ? s1_addr : run_left;
  assign nxt_right = hit ? s1_addr : run_right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      found     <= 1'b0;
      run_left  <= '0;
      run_right <= '0;
    end else if (state != SCAN) begin
      found     <= 1'b0;
    end else begin
      found     <= nxt_found;
      run_left  <= nxt_left;
      run_right <= nxt_right;
    end
  end

  // The last column is evaluated at cnt == DISPLAY_WIDTH; results register on
  // that edge so proj_done is high during the final SCAN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_left  <= '0;
      line_right <= RIGHT_DEFAULT;
      proj_done  <= 1'b0;
    end else if (state == SCAN && cnt == CW'(DISPLAY_WIDTH)) begin
      line_left  <= nxt_found ? 11'(nxt_left)  : 11'd0;
      line_right <= nxt_found ? 11'(nxt_right) : RIGHT_DEFAULT;
      proj_done  <= 1'b1;
    end else begin
      proj_done  <= 1'b0;
    end
  end

endmodule

// File: doc/vertical_projection.md
VERTICAL_PROJECTION -- requirements
Module: vertical_projection

Interface
REQ-001 Parameter DISPLAY_WIDTH, default 640: active pixels per line; this is also the column-histogram depth.
REQ-002 Parameter DISPLAY_HEIGHT, default 480: active lines per frame.
REQ-003 Parameter COL_THRESH, default 2: a column counts as ink only when its total is strictly greater than this value.
REQ-004 clk  input  1  pixel clock; one clock domain, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 vsync  input  1  frame sync; high during the active frame, low during blanking.
REQ-007 href  input  1  line reference; carried for interface symmetry, not used in decisions.
REQ-008 clken  input  1  pixel valid strobe.
REQ-009 bin  input  1  binarised pixel; 1 = ink, 0 = background.
REQ-010 line_top, line_bottom  input  11 each  row window from the horizontal projection block.
REQ-011 line_left, line_right  output  11 each  registered column bounds; these feed the horizontal projection block.
REQ-012 proj_done  output  1  one-clk pulse when line_left/line_right update.

Function
REQ-013 x_cnt/y_cnt shall clear while vsync=0.
- On clken, x_cnt increments.
- At DISPLAY_WIDTH-1, x_cnt wraps to 0 and y_cnt increments.
REQ-014 The block shall hold a DISPLAY_WIDTH x 10-bit column histogram (col_mem) with 1-cycle synchronous read.
REQ-015 FSM states: CLEAR, ACCUM, SCAN.
- Reset enters CLEAR.
- CLEAR -> ACCUM after writing 0 to addresses 0..DISPLAY_WIDTH-1, one per clk.
REQ-016 In ACCUM, accumulate only on pixels with clken=1, line_top < y_cnt < line_bottom (strict), and vsync=1.
- Each such pixel performs col_mem[x_cnt] += bin as read-modify-write.
- The write lands one clk after the read.
REQ-017 A read to an address with a write still pending shall use the pending write data (bypass), so back-to-back clken never loses a count.
REQ-018 Column counts shall saturate at 1023 and never wrap.
REQ-019 ACCUM -> SCAN on the clk after vsync is sampled falling (previous 1, current 0).
- Pixels arriving in SCAN or CLEAR are ignored.
REQ-020 SCAN reads addresses 0..DISPLAY_WIDTH-1 in consecutive clk cycles, independent of clken.
- Each address is written 0 the cycle after its read (clear-on-read).
REQ-021 During SCAN:
- left = lowest address with count > COL_THRESH.
- right = highest address with count > COL_THRESH.
REQ-022 One clk after the last read data is evaluated, line_left/line_right shall update together and proj_done=1 for exactly one clk; the FSM then returns to ACCUM.
- SCAN occupies DISPLAY_WIDTH+2 clks in total.
REQ-023 If no column qualifies, the outputs shall be line_left=0 and line_right=DISPLAY_WIDTH-1 (full-width window).
REQ-024 A single qualifying column shall give line_left = line_right = that column.
REQ-025 If vsync rises during SCAN, the SCAN still completes; accumulation resumes at the next pixel after ACCUM is entered, and that frame is partial.
REQ-026 line_bottom <= line_top+1 means no row qualifies; the result is the REQ-023 default.
REQ-027 line_left/line_right shall hold constant between proj_done pulses.

Reset
REQ-028 reset=0 shall immediately force:
- line_left=0, line_right=DISPLAY_WIDTH-1, proj_done=0.
- x_cnt=y_cnt=0.
- FSM to CLEAR.
REQ-029 Reset asserted mid-SCAN or mid-ACCUM shall discard partial results; CLEAR reruns in full after release.
REQ-030 col_mem has no reset; CLEAR is the only initialisation path.

Verification
REQ-031 Release reset, hold vsync=0 -> outputs 0/639, proj_done=0; ACCUM is reached exactly 640 clks after release.
REQ-032 Rectangle of bin=1 at x 100..199, y 50..149; line_top=10, line_bottom=300; continuous clken -> after vsync falls, proj_done at clk 642 of SCAN, line_left=100, line_right=199.
REQ-033 Ink only at y 5..8 with line_top=10, line_bottom=300 -> outputs 0/639, proj_done still pulses.
REQ-034 COL_THRESH=2: column 300 with 2 ink pixels, column 400 with 3 ink pixels, nothing else -> line_left=line_right=400.
REQ-035 Frame 1 ink at x 100..199, frame 2 ink at x 500..520 -> frame 2 gives 500/520, proving the clear-on-read.
REQ-036 Assert reset at SCAN address 320, release 5 clks later -> outputs 0/639, no proj_done; the next frame with the REQ-032 stimulus gives 100/199.
